adc_frame_aligner: RTL and testbench

Frame-clock alignment controller for the ADC LVDS receive path, sitting directly downstream of the MMCM clock generator in the divided (frame-rate) clock domain. It waits for the MMCM `locked`, sequences the ISERDES reset, and issues single-cycle `bitslip` pulses until the deserialized frame-clock word equals the expected pattern. It then declares alignment, monitors the frame word for errors, and re-aligns on request or on loss of lock.

---
 rtl/adc_frame_aligner.sv | 159 +++++++++++++++
 tb/tb_adc_frame_aligner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_aligner.sv
// Frame-clock alignment controller: sequences ISERDES reset after MMCM lock, bitslips
// until the frame word matches the expected pattern, then monitors it for errors.
module adc_frame_aligner #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = 8'hF0,
  parameter int                    RST_CYCLES    = 8,
  parameter int                    SETTLE_CYCLES = 4,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    MAX_SLIPS     = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mmcm_locked,
  input  logic [DATA_WIDTH-1:0] frame_data,
  input  logic                  realign,
  output logic                  serdes_rst,
  output logic                  bitslip,
  output logic                  aligned,
  output logic                  align_error,
  output logic                  frame_err,
  output logic [3:0]            slip_count,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SRST    = 3'd1,
    S_SETTLE  = 3'd2,
    S_CHECK   = 3'd3,
    S_SLIP    = 3'd4,
    S_VERIFY  = 3'd5,
    S_ALIGNED = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MC_W    = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [MC_W-1:0]  MATCH_LAST  = MC_W'(LOCK_COUNT - 1);
  localparam logic [3:0]       SLIP_MAX    = 4'(MAX_SLIPS);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MC_W-1:0]  match_cnt_q;
  logic             sync1_q;
  logic             locked_s_q;
  logic             serdes_rst_q;
  logic             bitslip_q;
  logic             aligned_q;
  logic             align_error_q;
  logic             frame_err_q;
  logic [3:0]       slip_cnt_q;
  logic             word_match;

  assign word_match = (frame_data == FRAME_PATTERN);

  // mmcm_locked is asynchronous to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= mmcm_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      match_cnt_q   <= '0;
      serdes_rst_q  <= 1'b1;
      bitslip_q     <= 1'b0;
      aligned_q     <= 1'b0;
      align_error_q <= 1'b0;
      frame_err_q   <= 1'b0;
      slip_cnt_q    <= '0;
    end else begin
      bitslip_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (!locked_s_q) begin
        state_q       <= S_IDLE;
        serdes_rst_q  <= 1'b1;
        aligned_q     <= 1'b0;
        align_error_q <= 1'b0;
        slip_cnt_q    <= '0;
      end else if (realign && (state_q != S_IDLE)) begin
        state_q       <= S_SRST;
        cnt_q         <= RST_LOAD;
        serdes_rst_q  <= 1'b1;
        aligned_q     <= 1'b0;
        align_error_q <= 1'b0;
        slip_cnt_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            serdes_rst_q <= 1'b1;
            state_q      <= S_SRST;
            cnt_q        <= RST_LOAD;
          end
          S_SRST: begin
            if (cnt_q == '0) begin
              state_q      <= S_SETTLE;
              cnt_q        <= SETTLE_LOAD;
              serdes_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_SETTLE: begin
            if (cnt_q == '0) state_q <= S_CHECK;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          // A mismatch while verifying restarts the search exactly like a failed first compare
          S_CHECK, S_VERIFY: begin
            if (word_match) begin
              if (state_q == S_CHECK) begin
                state_q     <= S_VERIFY;
                match_cnt_q <= MC_W'(1);
              end else if (match_cnt_q == MATCH_LAST) begin
                state_q   <= S_ALIGNED;
                aligned_q <= 1'b1;
              end else begin
                match_cnt_q <= match_cnt_q + 1'b1;
              end
            end else if (slip_cnt_q < SLIP_MAX) begin
              state_q    <= S_SLIP;
              bitslip_q  <= 1'b1;
              slip_cnt_q <= slip_cnt_q + 4'd1;
            end else begin
              state_q       <= S_ERROR;
              align_error_q <= 1'b1;
            end
          end
          S_SLIP: begin
            state_q <= S_SETTLE;
            cnt_q   <= SETTLE_LOAD;
          end
          S_ALIGNED: frame_err_q <= !word_match;
          S_ERROR:   state_q     <= S_ERROR;
          default:   state_q     <= S_IDLE;
        endcase
      end
    end
  end

  assign serdes_rst  = serdes_rst_q;
  assign bitslip     = bitslip_q;
  assign aligned     = aligned_q;
  assign align_error = align_error_q;
  assign frame_err   = frame_err_q;
  assign slip_count  = slip_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Directed bench for adc_frame_aligner with a behavioural ISERDES that rotates the
// frame word left by one bit two cycles after each bitslip pulse.
module tb_adc_frame_aligner;

  localparam int W = 32;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SRST    = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_VERIFY  = 3'd5;
  localparam logic [2:0] ST_ALIGNED = 3'd6;
  localparam logic [2:0] ST_ERROR   = 3'd7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mmcm_locked;
  logic [7:0] frame_data;
  logic       realign;
  logic       serdes_rst;
  logic       bitslip;
  logic       aligned;
  logic       align_error;
  logic       frame_err;
  logic [3:0] slip_count;
  logic [2:0] state_dbg;

  int checks      = 0;
  int errors      = 0;
  int edge_cnt    = 0;
  int pulse_cnt   = 0;
  int rot_pending = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  adc_frame_aligner #(
    .DATA_WIDTH   (8),
    .FRAME_PATTERN(8'hF0),
    .RST_CYCLES   (8),
    .SETTLE_CYCLES(4),
    .LOCK_COUNT   (16),
    .MAX_SLIPS    (7)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mmcm_locked(mmcm_locked),
    .frame_data (frame_data),
    .realign    (realign),
    .serdes_rst (serdes_rst),
    .bitslip    (bitslip),
    .aligned    (aligned),
    .align_error(align_error),
    .frame_err  (frame_err),
    .slip_count (slip_count),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // One clock edge; also runs the ISERDES model and scores bitslip pulses.
  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    #1;
    if (rot_pending > 0) begin
      rot_pending--;
      if (rot_pending == 0) frame_data = {frame_data[6:0], frame_data[7]};
    end
    if (bitslip === 1'b1) begin
      pulse_cnt++;
      rot_pending = 2;
      if (exp_q.size() > 0) check("bitslip_edge", W'(edge_cnt), exp_q.pop_front());
      else                  check("bitslip_unexpected", W'(edge_cnt), '0);
    end
  endtask

  task automatic run_to(input int n);
    while (edge_cnt < n) tick();
  endtask

  // Reset, load the raw word, then raise lock so the next edge is edge 1.
  task automatic start_run(input logic [7:0] word);
    reset_n     = 1'b0;
    mmcm_locked = 1'b0;
    realign     = 1'b0;
    frame_data  = word;
    rot_pending = 0;
    pulse_cnt   = 0;
    exp_q.delete();
    repeat (2) tick();
    reset_n     = 1'b1;
    mmcm_locked = 1'b1;
    edge_cnt    = 0;
  endtask

  initial begin
    reset_n     = 1'b0;
    mmcm_locked = 1'b0;
    realign     = 1'b0;
    frame_data  = 8'hF0;
    repeat (2) tick();
    check("rst_state", W'(state_dbg), W'(ST_IDLE));
    check("rst_serdes_rst", W'(serdes_rst), 1);
    check("rst_bitslip", W'(bitslip), 0);
    check("rst_aligned", W'(aligned), 0);
    check("rst_align_error", W'(align_error), 0);
    check("rst_frame_err", W'(frame_err), 0);
    check("rst_slip_count", W'(slip_count), 0);

    // pre-aligned input
    start_run(8'hF0);
    run_to(2);
    check("pre_idle_before_sync", W'(state_dbg), W'(ST_IDLE));
    run_to(3);
    check("pre_srst_entry", W'(state_dbg), W'(ST_SRST));
    run_to(10);
    check("pre_serdes_rst_held", W'(serdes_rst), 1);
    run_to(11);
    check("pre_serdes_rst_fall", W'(serdes_rst), 0);
    check("pre_settle", W'(state_dbg), W'(ST_SETTLE));
    run_to(15);
    check("pre_first_check", W'(state_dbg), W'(ST_CHECK));
    run_to(30);
    check("pre_not_yet_aligned", W'(aligned), 0);
    run_to(31);
    check("pre_aligned", W'(aligned), 1);
    check("pre_state_aligned", W'(state_dbg), W'(ST_ALIGNED));
    check("pre_slip_count", W'(slip_count), 0);
    check("pre_pulses", W'(pulse_cnt), 0);
    run_to(36);
    check("pre_no_frame_err", W'(frame_err), 0);

    // misaligned by 3: 8'h1E needs three left rotations to become 8'hF0
    start_run(8'h1E);
    exp_q.push_back(16);
    exp_q.push_back(22);
    exp_q.push_back(28);
    run_to(48);
    check("mis3_not_yet_aligned", W'(aligned), 0);
    run_to(49);
    check("mis3_aligned", W'(aligned), 1);
    check("mis3_slip_count", W'(slip_count), 3);
    check("mis3_pulses", W'(pulse_cnt), 3);
    check("mis3_exp_q_empty", W'(exp_q.size()), 0);

    // never matches: seven slips, then the error state
    start_run(8'h00);
    for (int k = 0; k < 7; k++) exp_q.push_back(W'(16 + 6 * k));
    run_to(57);
    check("nev_last_check", W'(state_dbg), W'(ST_CHECK));
    check("nev_no_error_yet", W'(align_error), 0);
    run_to(58);
    check("nev_align_error", W'(align_error), 1);
    check("nev_state_error", W'(state_dbg), W'(ST_ERROR));
    check("nev_slip_count", W'(slip_count), 7);
    check("nev_aligned", W'(aligned), 0);
    check("nev_pulses", W'(pulse_cnt), 7);
    run_to(60);
    check("nev_error_sticky", W'(align_error), 1);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    check("nev_realign_clr_err", W'(align_error), 0);
    check("nev_realign_serdes_rst", W'(serdes_rst), 1);
    check("nev_realign_slip_count", W'(slip_count), 0);
    check("nev_realign_state", W'(state_dbg), W'(ST_SRST));
    run_to(68);
    check("nev_srst_held", W'(serdes_rst), 1);
    run_to(69);
    check("nev_srst_fall", W'(serdes_rst), 0);

    // lock drop during VERIFY, then re-lock
    start_run(8'h1E);
    exp_q.push_back(16);
    exp_q.push_back(22);
    exp_q.push_back(28);
    run_to(40);
    check("drop_in_verify", W'(state_dbg), W'(ST_VERIFY));
    check("drop_slip_before", W'(slip_count), 3);
    mmcm_locked = 1'b0;
    run_to(42);
    check("drop_not_yet_serdes", W'(serdes_rst), 0);
    check("drop_not_yet_state", W'(state_dbg), W'(ST_VERIFY));
    run_to(43);
    check("drop_serdes_rst", W'(serdes_rst), 1);
    check("drop_state_idle", W'(state_dbg), W'(ST_IDLE));
    check("drop_slip_cleared", W'(slip_count), 0);
    run_to(45);
    mmcm_locked = 1'b1;
    edge_cnt    = 0;
    pulse_cnt   = 0;
    run_to(10);
    check("relock_srst_held", W'(serdes_rst), 1);
    run_to(11);
    check("relock_srst_fall", W'(serdes_rst), 0);
    run_to(30);
    check("relock_not_yet_aligned", W'(aligned), 0);
    run_to(31);
    check("relock_aligned", W'(aligned), 1);
    check("relock_pulses", W'(pulse_cnt), 0);

    // aligned monitoring: one bad word, then a realign request
    run_to(33);
    check("mon_no_err", W'(frame_err), 0);
    frame_data = 8'hE1;
    tick();
    frame_data = 8'hF0;
    check("mon_frame_err", W'(frame_err), 1);
    check("mon_still_aligned", W'(aligned), 1);
    tick();
    check("mon_frame_err_pulse", W'(frame_err), 0);
    check("mon_aligned_kept", W'(aligned), 1);
    run_to(36);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    check("re_aligned_cleared", W'(aligned), 0);
    check("re_serdes_rst", W'(serdes_rst), 1);
    check("re_state", W'(state_dbg), W'(ST_SRST));
    run_to(44);
    check("re_srst_held", W'(serdes_rst), 1);
    run_to(45);
    check("re_srst_fall", W'(serdes_rst), 0);
    run_to(64);
    check("re_not_yet_aligned", W'(aligned), 0);
    run_to(65);
    check("re_aligned", W'(aligned), 1);
    check("re_state_aligned", W'(state_dbg), W'(ST_ALIGNED));
    check("re_slip_count", W'(slip_count), 0);
    check("final_exp_q_empty", W'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
